// File: rtl/mipi_rx_lane_ctrl_if.sv
// Lane-side signal bundle between a MIPI_RX primitive/fabric and its lane sequencer.
// The slave modport is the sequencer view; the master modport is the PHY/environment view.
interface mipi_rx_lane_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             PLL_LOCK;
  logic             ENABLE;
  logic             LP_RX_DP;
  logic             LP_RX_DN;
  logic [WIDTH-1:0] HS_RX_DATA;
  logic             HS_RXD_VALID;
  logic             LP_EN;
  logic             RX_TERM_EN;
  logic             HS_EN;
  logic             BITSLIP_ADJ;
  logic             DLY_LOAD;
  logic             DLY_ADJ;
  logic             DLY_INCDEC;
  logic             ALIGNED;
  logic             ALIGN_ERR;
  logic [2:0]       STATE;

  modport master (
    output PLL_LOCK, ENABLE, LP_RX_DP, LP_RX_DN, HS_RX_DATA, HS_RXD_VALID,
    input  LP_EN, RX_TERM_EN, HS_EN, BITSLIP_ADJ, DLY_LOAD, DLY_ADJ, DLY_INCDEC,
           ALIGNED, ALIGN_ERR, STATE
  );

  modport slave (
    input  PLL_LOCK, ENABLE, LP_RX_DP, LP_RX_DN, HS_RX_DATA, HS_RXD_VALID,
    output LP_EN, RX_TERM_EN, HS_EN, BITSLIP_ADJ, DLY_LOAD, DLY_ADJ, DLY_INCDEC,
           ALIGNED, ALIGN_ERR, STATE
  );
endinterface

// File: rtl/mipi_rx_lane_ctrl.sv
// Per-lane D-PHY HS-entry sequencer and bitslip word aligner for MIPI_RX.
// Optional delay-tap sweep on slip exhaustion: define MIPI_RX_LANE_CTRL_DLY_SWEEP_EN.
module mipi_rx_lane_ctrl #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD     = WIDTH'(4'b1011),
  parameter int               T_TERM        = 4,
  parameter int               T_SETTLE      = 8,
  parameter int               SLIP_WAIT     = 3,
  parameter int               WORDS_PER_TRY = 4
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  mipi_rx_lane_ctrl_if.slave   lane
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STOP    = 3'd1,
    S_HS_RQST = 3'd2,
    S_TERM    = 3'd3,
    S_SETTLE  = 3'd4,
    S_ALIGN   = 3'd5,
    S_SLIP    = 3'd6,
    S_LOCKED  = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;

  logic lp_en_q, lp_en_d;
  logic rx_term_en_q, rx_term_en_d;
  logic hs_en_q, hs_en_d;
  logic bitslip_q, bitslip_d;
  logic dly_load_q, dly_load_d;
  logic aligned_q, aligned_d;
  logic align_err_q, align_err_d;

  logic do_slip, do_sweep, do_fail;
  logic lp11, lp01, lp00, lp10, run_ok;

`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
  // Local mirror of the MIPI_RX delay tap; DLY_LOAD reloads it to tap 0.
  logic [5:0] dly_tap_q, dly_tap_d;
  logic       dly_adj_q, dly_adj_d;
`endif

  assign lp11   =  lane.LP_RX_DP &  lane.LP_RX_DN;
  assign lp01   = ~lane.LP_RX_DP &  lane.LP_RX_DN;
  assign lp00   = ~lane.LP_RX_DP & ~lane.LP_RX_DN;
  assign lp10   =  lane.LP_RX_DP & ~lane.LP_RX_DN;
  assign run_ok =  lane.PLL_LOCK &  lane.ENABLE;

  // Next-state, timer and counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    timer_d    = (timer_q != 8'd0) ? timer_q - 8'd1 : timer_q;
    word_cnt_d = word_cnt_q;
    slip_cnt_d = slip_cnt_q;
    do_slip    = 1'b0;
    do_sweep   = 1'b0;
    do_fail    = 1'b0;
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
    dly_tap_d  = dly_tap_q;
`endif

    if (state_q != S_IDLE && !run_ok) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (run_ok && lp11) state_d = S_STOP;
        S_STOP:    if (lp01) state_d = S_HS_RQST;
        S_HS_RQST: begin
          if (lp00)      state_d = S_TERM;
          else if (lp11) state_d = S_STOP;
          else if (lp10) state_d = S_IDLE;
        end
        S_TERM:    if (timer_q == 8'd0) state_d = S_SETTLE;
        S_SETTLE: begin
          if (timer_q == 8'd0) begin
            state_d    = S_ALIGN;
            slip_cnt_d = 4'd0;
          end
        end
        S_ALIGN: begin
          if (lane.HS_RXD_VALID) begin
            // A match on the last word of a try wins over the slip decision.
            if (lane.HS_RX_DATA == SYNC_WORD) begin
              state_d = S_LOCKED;
            end else if (word_cnt_q == 8'(WORDS_PER_TRY - 1)) begin
              if (slip_cnt_q < 4'(WIDTH - 1)) begin
                state_d    = S_SLIP;
                do_slip    = 1'b1;
                slip_cnt_d = slip_cnt_q + 4'd1;
              end
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
              else if (dly_tap_q != 6'd63) begin
                state_d    = S_SLIP;
                do_sweep   = 1'b1;
                slip_cnt_d = 4'd0;
                dly_tap_d  = dly_tap_q + 6'd1;
              end
`endif
              else begin
                state_d = S_IDLE;
                do_fail = 1'b1;
              end
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
            end
          end
        end
        S_SLIP:    if (timer_q == 8'd0) state_d = S_ALIGN;
        S_LOCKED:  if (lp11 && !lane.HS_RXD_VALID) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    // The shared timer is loaded on entry; SLIP holds the pulse cycle plus SLIP_WAIT.
    if (state_d != state_q) begin
      case (state_d)
        S_TERM: begin
          timer_d = 8'(T_TERM - 1);
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
          dly_tap_d = 6'd0;
`endif
        end
        S_SETTLE: timer_d    = 8'(T_SETTLE - 1);
        S_SLIP:   timer_d    = 8'(SLIP_WAIT);
        S_ALIGN:  word_cnt_d = 8'd0;
        default:  ;
      endcase
    end
  end

  // Output decode from the next state so every output is a flop aligned with STATE.
  always_comb begin
    hs_en_d      = state_d inside {S_SETTLE, S_ALIGN, S_SLIP, S_LOCKED};
    lp_en_d      = ~hs_en_d;
    rx_term_en_d = hs_en_d | (state_d == S_TERM);
    aligned_d    = (state_d == S_LOCKED);
    dly_load_d   = (state_d == S_TERM) && (state_q != S_TERM);
    bitslip_d    = do_slip;
    align_err_d  = do_fail | (align_err_q & ~dly_load_d);
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
    dly_adj_d    = do_sweep;
`endif
  end

  always_ff @(posedge CLK_IN) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RST) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      word_cnt_q   <= 8'd0;
      slip_cnt_q   <= 4'd0;
      lp_en_q      <= 1'b1;
      rx_term_en_q <= 1'b0;
      hs_en_q      <= 1'b0;
      bitslip_q    <= 1'b0;
      dly_load_q   <= 1'b0;
      aligned_q    <= 1'b0;
      align_err_q  <= 1'b0;
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
      dly_tap_q    <= 6'd0;
      dly_adj_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      word_cnt_q   <= word_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      lp_en_q      <= lp_en_d;
      rx_term_en_q <= rx_term_en_d;
      hs_en_q      <= hs_en_d;
      bitslip_q    <= bitslip_d;
      dly_load_q   <= dly_load_d;
      aligned_q    <= aligned_d;
      align_err_q  <= align_err_d;
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
      dly_tap_q    <= dly_tap_d;
      dly_adj_q    <= dly_adj_d;
`endif
    end
  end

  assign lane.LP_EN       = lp_en_q;
  assign lane.RX_TERM_EN  = rx_term_en_q;
  assign lane.HS_EN       = hs_en_q;
  assign lane.BITSLIP_ADJ = bitslip_q;
  assign lane.DLY_LOAD    = dly_load_q;
  assign lane.ALIGNED     = aligned_q;
  assign lane.ALIGN_ERR   = align_err_q;
  assign lane.STATE       = state_q;
`ifdef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
  assign lane.DLY_ADJ     = dly_adj_q;
  assign lane.DLY_INCDEC  = dly_adj_q;
`else
  assign lane.DLY_ADJ     = 1'b0;
  assign lane.DLY_INCDEC  = 1'b0;
  logic unused_sweep;
  assign unused_sweep = do_sweep;
`endif

endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// Directed bench for mipi_rx_lane_ctrl: vector table for HS entry and alignment,
// plus hand sequences for slip exhaustion, aborts and reset during a slip.
module tb_mipi_rx_lane_ctrl;

  localparam int W = 4;

  // Packed output view: {LP_EN, RX_TERM_EN, HS_EN, BITSLIP_ADJ, DLY_LOAD, ALIGNED, ALIGN_ERR}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_TERM0 = 7'b1100100;
  localparam logic [6:0] O_TERM  = 7'b1100000;
  localparam logic [6:0] O_HS    = 7'b0110000;
  localparam logic [6:0] O_SLIPP = 7'b0111000;
  localparam logic [6:0] O_LOCK  = 7'b0110010;
  localparam logic [6:0] O_ERR   = 7'b1000001;

  localparam logic [1:0] LP11 = 2'b11, LP01 = 2'b01, LP00 = 2'b00;
  localparam logic [3:0] D_A = 4'b1010, D_SYNC = 4'b1011, D_N = 4'b1110;

  typedef struct {
    int         n;
    logic       rst_n;
    logic       pll;
    logic       en;
    logic [1:0] lp;
    logic [3:0] data;
    logic       valid;
    logic [6:0] exp_out;
    logic [2:0] exp_state;
  } vec_t;

  logic CLK_IN = 1'b0;
  logic RST    = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  vec_t tbl[$];

  mipi_rx_lane_ctrl_if #(.WIDTH(W)) lane ();

  mipi_rx_lane_ctrl #(
    .WIDTH(W), .SYNC_WORD(4'b1011), .T_TERM(4), .T_SETTLE(8),
    .SLIP_WAIT(3), .WORDS_PER_TRY(4)
  ) dut (
    .CLK_IN(CLK_IN),
    .RST   (RST),
    .lane  (lane)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t v(input int n, input logic rst_n, input logic [1:0] lp,
                             input logic [3:0] data, input logic valid,
                             input logic [6:0] eo, input logic [2:0] es);
    vec_t r;
    r.n = n; r.rst_n = rst_n; r.pll = 1'b1; r.en = 1'b1; r.lp = lp;
    r.data = data; r.valid = valid; r.exp_out = eo; r.exp_state = es;
    return r;
  endfunction

  function automatic logic [6:0] out_vec();
    return {lane.LP_EN, lane.RX_TERM_EN, lane.HS_EN, lane.BITSLIP_ADJ,
            lane.DLY_LOAD, lane.ALIGNED, lane.ALIGN_ERR};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int max_cyc, input string name);
    int k = 0;
    while (lane.STATE !== tgt && k < max_cyc) begin
      tick();
      k++;
    end
    check({name, ".state"}, 16'(lane.STATE), 16'(tgt));
  endtask

  task automatic enter_align(input string name);
    lane.HS_RXD_VALID = 1'b0;
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP11; tick();
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP01; tick();
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP00; tick();
    wait_state(3'd5, 20, name);
  endtask

  initial begin
    int pulses, last, min_gap, cyc;
    logic dly_seen;

    lane.PLL_LOCK = 1'b0; lane.ENABLE = 1'b0;
    lane.LP_RX_DP = 1'b1; lane.LP_RX_DN = 1'b1;
    lane.HS_RX_DATA = '0; lane.HS_RXD_VALID = 1'b0;

    // Nominal HS entry, two slips, match on the last word of a try, LP-11 exit.
    tbl.push_back(v(1, 1'b0, LP11, D_A,    1'b0, O_IDLE,  3'd0));
    tbl.push_back(v(1, 1'b1, LP11, D_A,    1'b0, O_IDLE,  3'd1));
    tbl.push_back(v(1, 1'b1, LP01, D_A,    1'b0, O_IDLE,  3'd2));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b0, O_TERM0, 3'd3));
    tbl.push_back(v(3, 1'b1, LP00, D_A,    1'b0, O_TERM,  3'd3));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b0, O_HS,    3'd4));
    tbl.push_back(v(7, 1'b1, LP00, D_A,    1'b0, O_HS,    3'd4));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b0, O_HS,    3'd5));
    tbl.push_back(v(3, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd5));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b1, O_SLIPP, 3'd6));
    tbl.push_back(v(3, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd6));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd5));
    tbl.push_back(v(3, 1'b1, LP00, D_SYNC, 1'b0, O_HS,    3'd5));
    tbl.push_back(v(3, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd5));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b1, O_SLIPP, 3'd6));
    tbl.push_back(v(3, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd6));
    tbl.push_back(v(1, 1'b1, LP00, D_A,    1'b1, O_HS,    3'd5));
    tbl.push_back(v(3, 1'b1, LP00, D_N,    1'b1, O_HS,    3'd5));
    tbl.push_back(v(1, 1'b1, LP00, D_SYNC, 1'b1, O_LOCK,  3'd7));
    tbl.push_back(v(2, 1'b1, LP11, D_SYNC, 1'b1, O_LOCK,  3'd7));
    tbl.push_back(v(1, 1'b1, LP11, D_SYNC, 1'b0, O_IDLE,  3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      RST               = tbl[i].rst_n;
      lane.PLL_LOCK     = tbl[i].pll;
      lane.ENABLE       = tbl[i].en;
      {lane.LP_RX_DP, lane.LP_RX_DN} = tbl[i].lp;
      lane.HS_RX_DATA   = tbl[i].data;
      lane.HS_RXD_VALID = tbl[i].valid;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d.out", i),   16'(out_vec()),    16'(tbl[i].exp_out));
      check($sformatf("vec%0d.state", i), 16'(lane.STATE),   16'(tbl[i].exp_state));
    end

    // Slip exhaustion: no sync word at any position.
    enter_align("exh");
    lane.HS_RX_DATA = 4'b0000;
    lane.HS_RXD_VALID = 1'b1;
    pulses = 0; last = 0; min_gap = 1000; cyc = 0; dly_seen = 1'b0;
    while (lane.STATE !== 3'd0 && cyc < 80) begin
      tick();
      cyc++;
      if (lane.BITSLIP_ADJ) begin
        if (pulses > 0 && (cyc - last) < min_gap) min_gap = cyc - last;
        last = cyc;
        pulses++;
      end
      if (lane.DLY_ADJ || lane.DLY_INCDEC) dly_seen = 1'b1;
    end
    check("exh.pulses",  16'(pulses),        16'd3);
    check("exh.gap_ge4", 16'(min_gap >= 4),  16'd1);
    check("exh.out",     16'(out_vec()),     16'(O_ERR));
    check("exh.state",   16'(lane.STATE),    16'd0);
`ifndef MIPI_RX_LANE_CTRL_DLY_SWEEP_EN
    check("exh.no_dly",  16'(dly_seen),      16'd0);
`endif

    // ALIGN_ERR stays set into STOP, then clears on the next TERM entry.
    lane.HS_RXD_VALID = 1'b0;
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP11; tick();
    check("sticky.err",   16'(lane.ALIGN_ERR), 16'd1);
    check("sticky.state", 16'(lane.STATE),     16'd1);
    enter_align("reentry");
    check("reentry.err",  16'(lane.ALIGN_ERR), 16'd0);

    // Abort from LOCKED on PLL loss.
    lane.HS_RX_DATA = D_SYNC; lane.HS_RXD_VALID = 1'b1; tick();
    check("lock.out", 16'(out_vec()), 16'(O_LOCK));
    lane.PLL_LOCK = 1'b0; tick();
    check("abort_pll.out",   16'(out_vec()),  16'(O_IDLE));
    check("abort_pll.state", 16'(lane.STATE), 16'd0);
    lane.PLL_LOCK = 1'b1; lane.HS_RXD_VALID = 1'b0;

    // Abort from TERM on ENABLE drop.
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP11; tick();
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP01; tick();
    {lane.LP_RX_DP, lane.LP_RX_DN} = LP00; tick();
    check("term.out", 16'(out_vec()), 16'(O_TERM0));
    lane.ENABLE = 1'b0; tick();
    check("abort_en.out",   16'(out_vec()),  16'(O_IDLE));
    check("abort_en.state", 16'(lane.STATE), 16'd0);
    lane.ENABLE = 1'b1;

    // Reset asserted on the BITSLIP_ADJ cycle.
    enter_align("rst_slip");
    lane.HS_RX_DATA = 4'b0000; lane.HS_RXD_VALID = 1'b1;
    cyc = 0;
    while (lane.BITSLIP_ADJ !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
    check("rst_slip.pulse", 16'(lane.BITSLIP_ADJ), 16'd1);
    RST = 1'b0; tick();
    check("rst_slip.out",   16'(out_vec()),  16'(O_IDLE));
    check("rst_slip.state", 16'(lane.STATE), 16'd0);
    tick();
    check("rst_slip.hold",  16'(out_vec()),  16'(O_IDLE));
    RST = 1'b1; tick();
    check("rst_slip.after", 16'(lane.STATE), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_rx_lane_ctrl.md
Name: mipi_rx_lane_ctrl

Overview:
- Per-lane sequencer for the MIPI_RX primitive.
- Tracks LP line states and walks the D-PHY HS-entry sequence: drives LP_EN, RX_TERM_EN and HS_EN.
- Word-aligns the deserialised stream by issuing BITSLIP_ADJ pulses until SYNC_WORD is seen.
- Returns the lane to LP mode on LP-11 (stop state) or PLL loss. Sits in the fabric clock domain beside each MIPI_RX instance.

Parameters:
- WIDTH, 4: deserialisation width; must match MIPI_RX WIDTH (4..10).
- SYNC_WORD, 4'b1011: WIDTH-bit alignment pattern compared against HS_RX_DATA.
- T_TERM, 4: cycles in TERM before HS_EN asserts (1..255).
- T_SETTLE, 8: cycles in SETTLE before alignment starts (1..255).
- SLIP_WAIT, 3: cycles after a BITSLIP_ADJ pulse before compares resume (1..255).
- WORDS_PER_TRY, 4: valid words compared per bit position (1..255).

Ports:
- CLK_IN  input  1  fabric clock; same clock as MIPI_RX CLK_IN.
- RST  input  1  synchronous, active-low reset.
- PLL_LOCK  input  1  PLL locked.
- ENABLE  input  1  lane enable.
- LP_RX_DP  input  1  LP receiver P.
- LP_RX_DN  input  1  LP receiver N.
- HS_RX_DATA  input  WIDTH  deserialised word.
- HS_RXD_VALID  input  1  word valid.
- LP_EN  output  1  LP receiver enable.
- RX_TERM_EN  output  1  HS termination enable.
- HS_EN  output  1  HS receiver enable.
- BITSLIP_ADJ  output  1  one-cycle bitslip request.
- DLY_LOAD  output  1  one-cycle delay-tap reload.
- DLY_ADJ  output  1  one-cycle tap step.
- DLY_INCDEC  output  1  tap direction (1 = increment).
- ALIGNED  output  1  lane word-locked.
- ALIGN_ERR  output  1  sticky alignment failure.
- STATE  output  3  current FSM state encoding.

Behaviour:
- All outputs are registered.
- Reset values: LP_EN=1; all other outputs 0; STATE=IDLE.
- State encoding: IDLE=0, STOP=1, HS_RQST=2, TERM=3, SETTLE=4, ALIGN=5, SLIP=6, LOCKED=7. All transitions take effect on the next CLK_IN edge.
- Line states use the pair {LP_RX_DP, LP_RX_DN}: LP-11 = {1,1}, LP-01 = {0,1}, LP-00 = {0,0}.
- IDLE: LP_EN=1, HS_EN=0, RX_TERM_EN=0. Go to STOP when ENABLE & PLL_LOCK & LP-11.
- STOP: go to HS_RQST on LP-01; otherwise stay.
- HS_RQST: go to TERM on LP-00. LP-11 returns to STOP; LP-10 returns to IDLE.
- TERM: RX_TERM_EN=1. DLY_LOAD pulses in the entry cycle. After T_TERM cycles, go to SETTLE.
- SETTLE: HS_EN=1 and LP_EN=0 from entry. After T_SETTLE cycles, go to ALIGN with word count and slip count cleared.
- ALIGN: each HS_RXD_VALID increments the word count.
  - HS_RX_DATA==SYNC_WORD on a valid word: go to LOCKED, ALIGNED=1 next cycle.
  - WORDS_PER_TRY valid words without a match: go to SLIP.
- SLIP:
  - If slip count < WIDTH-1: BITSLIP_ADJ=1 for exactly the entry cycle, slip count +1, wait SLIP_WAIT cycles, return to ALIGN with word count cleared.
  - Otherwise all WIDTH positions have been tried: ALIGN_ERR=1 (sticky), go to IDLE.
- LOCKED: ALIGNED=1 and HS path held. Exit to IDLE on LP-11 sampled while HS_RXD_VALID=0, or on ENABLE=0.
- Abort: PLL_LOCK=0 or ENABLE=0 in any state except IDLE returns to IDLE within one cycle. ALIGNED and HS_EN drop, RX_TERM_EN drops, LP_EN=1. This has priority over all other transitions.
- ALIGN_ERR clears on reset or on the next entry to TERM.
- Timers: one shared 8-bit down-counter, loaded on state entry.
- Simultaneous match and WORDS_PER_TRY reached on the same word: match wins.
- Reset mid-HS: all outputs take their reset values on the reset edge; no BITSLIP_ADJ pulse may be emitted.

Optional Feature:
- Macro: MIPI_RX_LANE_CTRL_DLY_SWEEP_EN.
- Defined: on slip exhaustion, if DLY_TAP_VALUE < 63, pulse DLY_ADJ with DLY_INCDEC=1, wait SLIP_WAIT cycles, clear slip count and re-enter ALIGN. ALIGN_ERR is set only when slips are exhausted at tap 63.
- Undefined: DLY_ADJ and DLY_INCDEC are tied to 0; slip exhaustion sets ALIGN_ERR immediately.

Test Plan:
- Nominal entry: ENABLE=1, PLL_LOCK=1, LP sequence 11→01→00 → RX_TERM_EN rises 1 cycle after LP-00 and DLY_LOAD pulses once; HS_EN rises 4 cycles later; STATE=5 after 8 more cycles.
- Alignment after slips: serial stream 1010 pattern then SYNC_WORD rotated by 2 → exactly 2 one-cycle BITSLIP_ADJ pulses at least 4 cycles apart; ALIGNED=1 once HS_RX_DATA==4'b1011.
- Slip exhaustion, macro off: stream with no 1011 at any rotation → 3 BITSLIP_ADJ pulses, then ALIGN_ERR=1, STATE=0, HS_EN=0.
- Delay sweep, macro on, with the same no-match stream → DLY_ADJ pulses with DLY_INCDEC=1 after every 3 slips; ALIGN_ERR only at tap 63.
- Abort: PLL_LOCK drops while LOCKED → next cycle ALIGNED=0, HS_EN=0, RX_TERM_EN=0, LP_EN=1, STATE=0.
- Reset mid-SLIP: RST=0 on the BITSLIP_ADJ cycle → next edge all outputs at reset values; ALIGN_ERR=0; LP_EN=1.
